hdmi_audio_gen: RTL and testbench

Parametrised HDMI audio front end feeding the hdmi core's clk_audio and audio_sample_word inputs. It replaces the fixed integer audio clock divider and the combinational 2-bit volume mux in the video top level. It provides:
- An exact-average fractional sample clock for any pixel clock.
- N-channel sample capture.
- A wider log-step volume control with click-free ramping.
- Optional mono downmix.

---
 rtl/hdmi_audio_pkg.sv | 25 ++
 rtl/hdmi_audio_gen_nco.sv | 50 +++++
 rtl/hdmi_audio_gen.sv | 111 +++++++++++
 tb/tb_hdmi_audio_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared constants and elaboration-time helpers for the HDMI audio front end.
package hdmi_audio_pkg;

  // Volume code that silences the output; also the ramp start after reset.
  localparam int VOL_MUTE = 0;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int clog2(input longint value);
    int r;
    r = 0;
    while ((longint'(1) << r) < value) r++;
    return r;
  endfunction

  // The NCO accumulator must hold acc + step, which stays below 2*CLK_HZ.
  function automatic int acc_width(input longint clk_hz);
    return clog2(clk_hz) + 1;
  endfunction

  // Right-shift amount for a volume code: full scale needs no shift.
  function automatic int vol_shift(input int k, input int vol_bits);
    return ((2 ** vol_bits) - 1) - k;
  endfunction

endpackage

// File: rtl/hdmi_audio_gen_nco.sv
// Fractional-rate strobe generator: toggles a square wave whose average
// frequency is exactly STEP_HZ/2 for a clock of CLK_HZ, and pulses on each
// rising edge of that square wave.
module audio_nco
  import hdmi_audio_pkg::*;
#(
  parameter int CLK_HZ  = 27000000,
  parameter int STEP_HZ = 96000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic clk_audio_o,
  output logic sample_tick_o
);

  localparam int AW = acc_width(CLK_HZ);
  localparam logic [AW-1:0] LIMIT = AW'(CLK_HZ);
  localparam logic [AW-1:0] STEP  = AW'(STEP_HZ);

  logic [AW-1:0] acc_q, acc_d, sum;
  logic          wrap;
  logic          clk_audio_q, clk_audio_d;
  logic          tick_q, tick_d;

  // Phase accumulate with modular wrap; each wrap is one half-period edge.
  always_comb begin
    sum         = acc_q + STEP;
    wrap        = (sum >= LIMIT);
    acc_d       = wrap ? (sum - LIMIT) : sum;
    clk_audio_d = clk_audio_q ^ wrap;
    tick_d      = wrap & ~clk_audio_q;
  end

  // Accumulator, square wave and rising-edge pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      clk_audio_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      clk_audio_q <= clk_audio_d;
      tick_q      <= tick_d;
    end
  end

  assign clk_audio_o   = clk_audio_q;
  assign sample_tick_o = tick_q;

endmodule

// File: rtl/hdmi_audio_gen.sv
// HDMI audio front end: fractional sample clock, per-tick sample capture,
// optional mono downmix and ramped log-step volume scaling.
module hdmi_audio_gen
  import hdmi_audio_pkg::*;
#(
  parameter int CLK_HZ   = 27000000,
  parameter int RATE_HZ  = 48000,
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int VOL_BITS = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] audio_in,
  input  logic [VOL_BITS-1:0]       volume,
  input  logic                      mute,
  input  logic                      mono,
  output logic                      clk_audio,
  output logic                      sample_tick,
  output logic [CHANNELS*WIDTH-1:0] audio_out,
  output logic                      sample_valid,
  output logic [VOL_BITS-1:0]       vol_cur
);

  logic                      tick;
  logic [CHANNELS*WIDTH-1:0] raw_p0_q;
  logic                      mono_p0_q;
  logic                      vld_p0_q;
  logic [VOL_BITS-1:0]       vol_q, vol_d, target;
  logic signed [WIDTH-1:0]   mix_p1;
  logic [CHANNELS*WIDTH-1:0] scaled_p1;
  logic [CHANNELS*WIDTH-1:0] audio_out_q;
  logic                      vld_p1_q;

  // Downmix of two channels; the extra sum bit avoids overflow and the
  // arithmetic halving rounds toward minus infinity.
  function automatic logic signed [WIDTH-1:0] mono_mix(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    return s[WIDTH:1];
  endfunction

  // Log-step attenuation: code 0 silences, otherwise shift by distance from full scale.
  function automatic logic signed [WIDTH-1:0] scale_sample(input logic signed [WIDTH-1:0] x,
                                                           input logic [VOL_BITS-1:0] k);
    if (k == VOL_BITS'(VOL_MUTE)) return '0;
    return x >>> vol_shift(int'(k), VOL_BITS);
  endfunction

  audio_nco #(
    .CLK_HZ (CLK_HZ),
    .STEP_HZ(2 * RATE_HZ)
  ) u_nco (
    .clk_i        (clk),
    .rst_ni       (resetn),
    .clk_audio_o  (clk_audio),
    .sample_tick_o(tick)
  );

  assign sample_tick = tick;

  // ---- stage p0: capture samples and mono select on the tick ----
  // Sample data needs no reset: nothing downstream uses it before the first valid.
  always_ff @(posedge clk) begin
    if (tick) begin
      raw_p0_q  <= audio_in;
      mono_p0_q <= mono;
    end
  end

  // One ramp step per tick toward the mute-aware target; redirects mid-ramp.
  always_comb begin
    target = mute ? VOL_BITS'(VOL_MUTE) : volume;
    vol_d  = vol_q;
    if (tick) begin
      if (vol_q < target)      vol_d = vol_q + VOL_BITS'(1);
      else if (vol_q > target) vol_d = vol_q - VOL_BITS'(1);
    end
  end

  // ---- stage p1: downmix and scale with the freshly stepped volume ----
  assign mix_p1 = mono_mix(signed'(raw_p0_q[WIDTH-1:0]), signed'(raw_p0_q[2*WIDTH-1:WIDTH]));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [WIDTH-1:0] src_p1;
    assign src_p1 = mono_p0_q ? mix_p1 : signed'(raw_p0_q[c*WIDTH +: WIDTH]);
    assign scaled_p1[c*WIDTH +: WIDTH] = scale_sample(src_p1, vol_q);
  end

  // Volume, valid pipeline and output hold registers; reset flushes them all.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vol_q       <= VOL_BITS'(VOL_MUTE);
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      audio_out_q <= '0;
    end else begin
      vol_q    <= vol_d;
      vld_p0_q <= tick;
      vld_p1_q <= vld_p0_q;
      if (vld_p0_q) audio_out_q <= scaled_p1;
    end
  end

  // ---- stage p2: outputs ----
  assign audio_out    = audio_out_q;
  assign sample_valid = vld_p1_q;
  assign vol_cur      = vol_q;

endmodule

// File: tb/tb_hdmi_audio_gen.sv
// Directed bench for hdmi_audio_gen: default-rate instance for the data path
// and ramp, plus a small-clock instance for exact NCO tick accounting.
module tb_hdmi_audio_gen;

  logic        clk = 1'b0;
  logic        resetn, rstb_n;
  logic [31:0] audio_in;
  logic [2:0]  volume;
  logic        mute, mono;

  logic        clk_audio, sample_tick, sample_valid;
  logic [31:0] audio_out;
  logic [2:0]  vol_cur;

  logic        clk_audio_b, sample_tick_b, sample_valid_b;
  logic [31:0] audio_out_b;
  logic [2:0]  vol_cur_b;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] EXP_UP0 [7] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800,
                                         16'h1000, 16'h2000, 16'h4000};
  localparam logic [15:0] EXP_UP1 [7] = '{16'hFF00, 16'hFE00, 16'hFC00, 16'hF800,
                                         16'hF000, 16'hE000, 16'hC000};
  localparam logic [2:0]  EXP_MUTE_VOL [6] = '{3'd6, 3'd5, 3'd4, 3'd5, 3'd6, 3'd7};

  always #5 clk = ~clk;

  hdmi_audio_gen dut (
    .clk         (clk),
    .resetn      (resetn),
    .audio_in    (audio_in),
    .volume      (volume),
    .mute        (mute),
    .mono        (mono),
    .clk_audio   (clk_audio),
    .sample_tick (sample_tick),
    .audio_out   (audio_out),
    .sample_valid(sample_valid),
    .vol_cur     (vol_cur)
  );

  hdmi_audio_gen #(.CLK_HZ(1000), .RATE_HZ(48)) dut_b (
    .clk         (clk),
    .resetn      (rstb_n),
    .audio_in    (audio_in),
    .volume      (volume),
    .mute        (mute),
    .mono        (mono),
    .clk_audio   (clk_audio_b),
    .sample_tick (sample_tick_b),
    .audio_out   (audio_out_b),
    .sample_valid(sample_valid_b),
    .vol_cur     (vol_cur_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance until sample_valid is seen (bounded), sampled 1 time unit after the edge.
  task automatic next_valid(input string tag);
    int i;
    i = 0;
    do begin
      @(posedge clk); #1;
      i++;
    end while (!sample_valid && i < 1200);
    check({tag, "_seen"}, 32'(sample_valid), 32'd1);
  endtask

  initial begin
    int n_ticks, last_tick, sp_min, sp_max;
    int last_edge, ph_min, ph_max;
    logic prev_ca;
    int i;

    resetn   = 1'b0;
    rstb_n   = 1'b0;
    audio_in = {16'hC000, 16'h4000};
    volume   = 3'd7;
    mute     = 1'b0;
    mono     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_audio", 32'(clk_audio), 32'd0);
    check("rst_tick",      32'(sample_tick), 32'd0);
    check("rst_valid",     32'(sample_valid), 32'd0);
    check("rst_audio_out", audio_out, 32'd0);
    check("rst_vol_cur",   32'(vol_cur), 32'd0);
    resetn = 1'b1;

    // Ramp up from mute to full scale, then stable.
    for (int k = 0; k < 7; k++) begin
      next_valid($sformatf("up%0d", k));
      check($sformatf("up%0d_vol", k), 32'(vol_cur), 32'(k + 1));
      check($sformatf("up%0d_ch0", k), 32'(audio_out[15:0]), 32'(EXP_UP0[k]));
      check($sformatf("up%0d_ch1", k), 32'(audio_out[31:16]), 32'(EXP_UP1[k]));
    end
    next_valid("stable");
    check("stable_ch0", 32'(audio_out[15:0]), 32'h4000);
    check("stable_vol", 32'(vol_cur), 32'd7);
    @(posedge clk); #1;
    check("valid_one_cycle", 32'(sample_valid), 32'd0);
    check("out_hold", 32'(audio_out[15:0]), 32'h4000);

    // Mono downmix at unity.
    mono     = 1'b1;
    audio_in = {16'h7FFF, 16'h7FFF};
    next_valid("mono_a");
    check("mono_a_out", audio_out, {16'h7FFF, 16'h7FFF});
    audio_in = {16'h8000, 16'h7FFF};
    next_valid("mono_b");
    check("mono_b_out", audio_out, {16'hFFFF, 16'hFFFF});

    // Ramp down to 5 with sign-preserving shift.
    mono     = 1'b0;
    volume   = 3'd5;
    audio_in = {16'h7FFF, 16'h8000};
    next_valid("v6");
    check("v6_vol", 32'(vol_cur), 32'd6);
    check("v6_ch0", 32'(audio_out[15:0]), 32'hC000);
    next_valid("v5");
    check("v5_vol", 32'(vol_cur), 32'd5);
    check("v5_out", audio_out, {16'h1FFF, 16'hE000});

    // Back to 7, then mute for 3 ticks and release.
    volume = 3'd7;
    next_valid("r6");
    check("r6_vol", 32'(vol_cur), 32'd6);
    next_valid("r7");
    check("r7_vol", 32'(vol_cur), 32'd7);
    mute = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) mute = 1'b0;
      next_valid($sformatf("mute%0d", k));
      check($sformatf("mute%0d_vol", k), 32'(vol_cur), 32'(EXP_MUTE_VOL[k]));
    end

    // Reset one cycle after a tick drops the pending valid and restarts the ramp.
    audio_in = {16'hC000, 16'h4000};
    i = 0;
    do begin
      @(posedge clk); #1;
      i++;
    end while (!sample_tick && i < 1200);
    check("pre_rst_tick_seen", 32'(sample_tick), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("midrst_vol", 32'(vol_cur), 32'd0);
    check("midrst_out", audio_out, 32'd0);
    check("midrst_clk_audio", 32'(clk_audio), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_valid%0d", k), 32'(sample_valid), 32'd0);
      check($sformatf("midrst_tick%0d", k), 32'(sample_tick), 32'd0);
    end
    resetn = 1'b1;
    next_valid("restart");
    check("restart_vol", 32'(vol_cur), 32'd1);
    check("restart_out", audio_out, {16'hFF00, 16'h0100});

    // NCO accounting on the 1 kHz / 48 Hz instance.
    n_ticks = 0; last_tick = -1; sp_min = 1000; sp_max = 0;
    last_edge = -1; ph_min = 1000; ph_max = 0;
    prev_ca = 1'b0;
    rstb_n = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      if (sample_tick_b) begin
        n_ticks++;
        if (last_tick >= 0) begin
          if (c - last_tick < sp_min) sp_min = c - last_tick;
          if (c - last_tick > sp_max) sp_max = c - last_tick;
        end
        last_tick = c;
      end
      if (clk_audio_b != prev_ca) begin
        if (last_edge >= 0) begin
          if (c - last_edge < ph_min) ph_min = c - last_edge;
          if (c - last_edge > ph_max) ph_max = c - last_edge;
        end
        last_edge = c;
        prev_ca = clk_audio_b;
      end
    end
    check("nco_ticks",  32'(n_ticks), 32'd48);
    check("nco_sp_min", 32'(sp_min), 32'd20);
    check("nco_sp_max", 32'(sp_max), 32'd21);
    check("nco_ph_min", 32'(ph_min), 32'd10);
    check("nco_ph_max", 32'(ph_max), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
